// File: rtl/grid_update_scanner.sv
// Per-frame cell scanner: encodes object flags per (x,y), issues only changed cells to the LCD.
// Optional BORDER_GEN_EN: walls are generated from the grid edge instead of the border input.
module grid_update_scanner #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      start_frame,
  input  logic                      snake_head,
  input  logic                      snake_body,
  input  logic                      apple,
  input  logic                      border,
  input  logic                      game_over,
  input  logic                      cmd_done,
  output logic [$clog2(GRID_W)-1:0] x,
  output logic [$clog2(GRID_H)-1:0] y,
  output logic [CODE_W-1:0]         obj_code,
  output logic                      en_update,
  output logic                      diff,
  output logic                      init_cycle,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_CMD, DONE} state_t;

  state_t              state, state_d;
  logic [CODE_W-1:0]   frame_mem [CELLS];
  logic [CODE_W-1:0]   cell_code;
  logic [IDX_W-1:0]    idx;
  logic                wall, issue, advance, last_cell, enter_scan;
  logic                pending, gameover_drawn;

`ifdef BORDER_GEN_EN
  logic border_unused;
  assign border_unused = border;
  assign wall = (x == '0) || (x == X_W'(GRID_W-1)) || (y == '0) || (y == Y_W'(GRID_H-1));
`else
  assign wall = border;
`endif

  // Game-over overlay: walls keep their code, everything else becomes 5.
  always_comb begin
    cell_code = '0;
    if (game_over)       cell_code = wall ? CODE_W'(4) : CODE_W'(5);
    else if (snake_head) cell_code = CODE_W'(1);
    else if (snake_body) cell_code = CODE_W'(2);
    else if (apple)      cell_code = CODE_W'(3);
    else if (wall)       cell_code = CODE_W'(4);
  end

  assign idx        = IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
  assign diff       = (cell_code != frame_mem[idx]);
  assign last_cell  = (x == X_W'(GRID_W-1)) && (y == Y_W'(GRID_H-1));
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    issue      = 1'b0;
    advance    = 1'b0;
    enter_scan = 1'b0;
    case (state)
      IDLE: if (start_frame || pending) begin
        state_d    = SCAN;
        enter_scan = 1'b1;
      end
      SCAN: begin
        issue = diff || init_cycle || (game_over && !gameover_drawn);
        if (issue) state_d = WAIT_CMD;
        else begin
          advance = 1'b1;
          if (last_cell) state_d = DONE;
        end
      end
      WAIT_CMD: if (cmd_done) begin
        advance = 1'b1;
        state_d = last_cell ? DONE : SCAN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      x              <= '0;
      y              <= '0;
      obj_code       <= '0;
      en_update      <= 1'b0;
      init_cycle     <= 1'b1;
      pending        <= 1'b0;
      gameover_drawn <= 1'b0;
      for (int i = 0; i < CELLS; i++) frame_mem[i] <= '0;
    end else begin
      en_update <= issue;
      if (enter_scan) begin
        x <= '0;
        y <= '0;
      end else if (advance && !last_cell) begin
        if (x == X_W'(GRID_W-1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (issue) begin
        obj_code       <= cell_code;
        frame_mem[idx] <= cell_code;
      end
      // Single-deep request queue; IDLE always consumes it.
      if (state == IDLE)    pending <= 1'b0;
      else if (start_frame) pending <= 1'b1;
      if (state == DONE) init_cycle <= 1'b0;
      if (!game_over)                    gameover_drawn <= 1'b0;
      else if (state == DONE)            gameover_drawn <= 1'b1;
    end
  end
endmodule
